chunked_addsub: RTL and testbench

CHUNKED_ADDSUB -- requirements
Module: chunked_addsub

---
 rtl/chunked_addsub.sv | 146 ++++++++++++++
 tb/tb_chunked_addsub.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract that walks an N-bit operand pair C bits per clock, LSB chunk first,
// with a registered carry/borrow chain and a ready/valid handshake on both sides.
module chunked_addsub #(
  parameter int N = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  localparam int K  = N / C;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  if (N < 1 || C < 1 || C > N || (N % C) != 0) begin : g_bad_params
    $error("chunked_addsub: need N >= 1, 1 <= C <= N and N %% C == 0");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_op;
  logic          r_chain;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_result;
  logic          r_cout;
  logic          r_zero;
  logic          r_neg;
  logic          r_ovf;
  logic          r_out_valid;

  logic [C-1:0]  w_ca;
  logic [C-1:0]  w_cb;
  logic [C-1:0]  w_sum;
  logic [C:0]    w_ch;
  logic [N-1:0]  w_acc_next;
  logic          w_last;
  logic          w_ovf;

  assign w_ca   = r_a[r_k*C +: C];
  assign w_cb   = r_b[r_k*C +: C];
  assign w_last = (r_k == KW'(K - 1));

  // One chunk of the ripple chain; w_ch[0] is the carry/borrow left by the previous chunk.
  // NOTE: every always_comb output gets a default before any conditional write, so no latch.
  always_comb begin
    w_sum   = '0;
    w_ch    = '0;
    w_ch[0] = r_chain;
    for (int i = 0; i < C; i++) begin
      w_sum[i] = w_ca[i] ^ w_cb[i] ^ w_ch[i];
      if (r_op)
        w_ch[i+1] = (w_ca[i] & w_cb[i]) | ((w_ca[i] ^ w_cb[i]) & w_ch[i]);
      else
        w_ch[i+1] = (~w_ca[i] & w_cb[i]) | (~(w_ca[i] ^ w_cb[i]) & w_ch[i]);
    end
  end

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_k*C +: C] = w_sum;
  end

  assign w_ovf = r_op ? ((r_a[N-1] == r_b[N-1]) & (w_acc_next[N-1] != r_a[N-1]))
                      : ((r_a[N-1] != r_b[N-1]) & (w_acc_next[N-1] != r_a[N-1]));

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 1'b0;
      r_chain     <= 1'b0;
      r_acc       <= '0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_chain <= cin;
            r_k     <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_chain <= w_ch[C];
          if (w_last) begin
            // Published fields change only here, so partial chunks never appear as valid.
            r_result    <= w_acc_next;
            r_cout      <= w_ch[C];
            r_zero      <= (w_acc_next == '0);
            r_neg       <= w_acc_next[N-1];
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by rst so in_ready is low throughout reset and high as soon as it is released.
  assign in_ready  = (r_state == IDLE) & ~rst;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed vectors on an N=8/C=4 instance plus random ops on N=16 with C=16 and C=1,
// checked against wide-integer reference arithmetic.
module tb_chunked_addsub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- N=8, C=4 instance ----------------
  logic       d_in_valid = 1'b0, d_op = 1'b0, d_cin = 1'b0, d_out_ready = 1'b0;
  logic [7:0] d_a = '0, d_b = '0;
  logic       d_in_ready, d_out_valid, d_cout, d_zero, d_neg, d_ovf;
  logic [7:0] d_result;

  chunked_addsub #(.N(8), .C(4)) u_n8 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .op(d_op), .cin(d_cin), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .result(d_result), .cout(d_cout), .zero(d_zero),
    .neg(d_neg), .ovf(d_ovf)
  );

  // ---------------- N=16 instances: [0] C=16, [1] C=1 ----------------
  logic        v16[2], op16[2], cin16[2], ordy16[2];
  logic [15:0] a16[2], b16[2];
  logic        irdy16[2], ov16[2], co16[2], z16[2], n16[2], of16[2];
  logic [15:0] r16[2];

  chunked_addsub #(.N(16), .C(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(v16[0]), .in_ready(irdy16[0]),
    .a(a16[0]), .b(b16[0]), .op(op16[0]), .cin(cin16[0]), .out_valid(ov16[0]),
    .out_ready(ordy16[0]), .result(r16[0]), .cout(co16[0]), .zero(z16[0]),
    .neg(n16[0]), .ovf(of16[0])
  );

  chunked_addsub #(.N(16), .C(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(v16[1]), .in_ready(irdy16[1]),
    .a(a16[1]), .b(b16[1]), .op(op16[1]), .cin(cin16[1]), .out_valid(ov16[1]),
    .out_ready(ordy16[1]), .result(r16[1]), .cout(co16[1]), .zero(z16[1]),
    .neg(n16[1]), .ovf(of16[1])
  );

  typedef struct packed {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [3:0] flags; // {cout, zero, neg, ovf}
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                              input logic cin_i, input logic [7:0] res_i, input logic [3:0] fl_i);
    vec_t v;
    v.op = op_i; v.a = a_i; v.b = b_i; v.cin = cin_i; v.res = res_i; v.flags = fl_i;
    return v;
  endfunction

  // Reference: {result, cout, zero, neg, ovf} from plain wide arithmetic.
  function automatic logic [19:0] ref16(input logic op_i, input logic [15:0] a_i,
                                        input logic [15:0] b_i, input logic cin_i);
    logic [16:0] t;
    logic        v;
    if (op_i) t = {1'b0, a_i} + {1'b0, b_i} + {16'b0, cin_i};
    else      t = {1'b0, a_i} - {1'b0, b_i} - {16'b0, cin_i};
    if (op_i) v = (a_i[15] == b_i[15]) && (t[15] != a_i[15]);
    else      v = (a_i[15] != b_i[15]) && (t[15] != a_i[15]);
    return {t[15:0], t[16], (t[15:0] == 16'h0), t[15], v};
  endfunction

  // Issue one request on the 8-bit instance and return cycles from accept edge to out_valid.
  task automatic run8(input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                      input logic cin_i, output int lat);
    @(negedge clk);
    check("n8_in_ready_idle", d_in_ready, 1);
    d_in_valid = 1'b1; d_op = op_i; d_a = a_i; d_b = b_i; d_cin = cin_i;
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_op = ~op_i; d_a = ~a_i; d_b = 8'h5A; d_cin = ~cin_i;
    lat = 0;
    while (!d_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release8(input string tag);
    check({tag, "_in_ready_done"}, d_in_ready, 0);
    @(negedge clk);
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, d_out_valid, 0);
    check({tag, "_in_ready_next"}, d_in_ready, 1);
  endtask

  task automatic run16(input int s, input int exp_lat, input int n_ops, input string tag);
    for (int t = 0; t < n_ops; t++) begin
      logic [15:0] ra, rb;
      logic        rop, rcin;
      int          lat;
      ra   = 16'($urandom);
      rb   = (t % 8 == 0) ? ra : 16'($urandom);
      rop  = 1'($urandom_range(0, 1));
      rcin = (t % 8 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      v16[s] = 1'b1; a16[s] = ra; b16[s] = rb; op16[s] = rop; cin16[s] = rcin;
      @(posedge clk); #1;
      v16[s] = 1'b0; a16[s] = 16'($urandom); b16[s] = 16'($urandom);
      lat = 0;
      while (!ov16[s] && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_fields"}, {r16[s], co16[s], z16[s], n16[s], of16[s]}, ref16(rop, ra, rb, rcin));
      @(negedge clk);
      ordy16[s] = 1'b1;
      @(posedge clk); #1;
      ordy16[s] = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "testbench timeout");
  end

  initial begin
    int lat;
    int seen;

    for (int s = 0; s < 2; s++) begin
      v16[s] = 1'b0; op16[s] = 1'b0; cin16[s] = 1'b0; ordy16[s] = 1'b0;
      a16[s] = '0; b16[s] = '0;
    end

    vecs[0]  = mk(1'b0, 8'h35, 8'h12, 1'b0, 8'h23, 4'b0000);
    vecs[1]  = mk(1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1010);
    vecs[2]  = mk(1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001);
    vecs[3]  = mk(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011);
    vecs[4]  = mk(1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1100);
    vecs[5]  = mk(1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 4'b1101);
    vecs[6]  = mk(1'b0, 8'h10, 8'h01, 1'b0, 8'h0F, 4'b0000);
    vecs[7]  = mk(1'b0, 8'h05, 8'h05, 1'b1, 8'hFF, 4'b1010);
    vecs[8]  = mk(1'b1, 8'h0F, 8'h01, 1'b0, 8'h10, 4'b0000);
    vecs[9]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0100);
    vecs[10] = mk(1'b1, 8'h3C, 8'hC4, 1'b0, 8'h00, 4'b1100);
    vecs[11] = mk(1'b0, 8'h7F, 8'hFF, 1'b0, 8'h80, 4'b1011);

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_result", d_result, 8'h00);
    check("rst_flags", {d_cout, d_zero, d_neg, d_ovf}, 4'b0000);
    check("rst_out_valid", d_out_valid, 0);
    check("rst_in_ready", d_in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", d_in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_result", i), d_result, vecs[i].res);
      check($sformatf("vec%0d_flags", i), {d_cout, d_zero, d_neg, d_ovf}, vecs[i].flags);
      release8($sformatf("vec%0d", i));
    end

    // Reset after the first chunk of a run: outputs clear without a clock, no late completion.
    @(negedge clk);
    d_in_valid = 1'b1; d_op = 1'b0; d_a = 8'h55; d_b = 8'h11; d_cin = 1'b0;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrun_rst_result", d_result, 8'h00);
    check("midrun_rst_flags", {d_cout, d_zero, d_neg, d_ovf}, 4'b0000);
    check("midrun_rst_out_valid", d_out_valid, 0);
    check("midrun_rst_in_ready", d_in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun_release_in_ready", d_in_ready, 1);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (d_out_valid) seen++;
    end
    check("midrun_no_late_valid", seen, 0);
    run8(1'b0, 8'h10, 8'h01, 1'b0, lat);
    check("post_rst_latency", lat, 2);
    check("post_rst_result", d_result, 8'h0F);
    check("post_rst_flags", {d_cout, d_zero, d_neg, d_ovf}, 4'b0000);
    release8("post_rst");

    // Backpressure with operand/in_valid/out_ready noise during RUN and DONE.
    @(negedge clk);
    d_in_valid = 1'b1; d_op = 1'b0; d_a = 8'h35; d_b = 8'h12; d_cin = 1'b0;
    @(posedge clk); #1;
    d_a = 8'hFF; d_b = 8'hFF; d_op = 1'b1; d_cin = 1'b1; d_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_run_out_valid", d_out_valid, 0);
    d_out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_done_out_valid", d_out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_result", c), d_result, 8'h23);
      check($sformatf("bp_hold%0d_flags", c), {d_cout, d_zero, d_neg, d_ovf}, 4'b0000);
      check($sformatf("bp_hold%0d_valid_ready", c), {d_out_valid, d_in_ready}, 2'b10);
    end
    d_in_valid = 1'b0;
    release8("bp");

    run16(0, 1, 1000, "c16");
    run16(1, 16, 1000, "c1");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
